// File: rtl/sanduba_multi.sv
// Multi-product credit vending controller: coin accumulation, priced dispense, refund and overflow bounce.
// Optional macro SANDUBA_MULTI_AUTO_CHANGE_EN: after a sale, leftover credit is paid back as change.
module sanduba_multi #(
   parameter int                   N_PROD = 3,
   parameter int                   CW     = 5,
   parameter logic [N_PROD*CW-1:0] PRICES = {5'd4, 5'd3, 5'd2}
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              m100_i,
   input  logic              dev_i,
   input  logic [N_PROD-1:0] req_i,
   output logic [N_PROD-1:0] grant_o,
   output logic              d100_o,
   output logic              busy_o,
   output logic [CW-1:0]     credit_o
);

   // state  | meaning
   // IDLE   | waiting; only state that samples inputs
   // ADD    | accept one coin, credit +1 on exit
   // SERVE  | dispense product prod_q, credit -= price on exit
   // REJECT | invalid or unaffordable request, no effect
   // BOUNCE | coin returned because credit is saturated
   // REFUND | return one coin per cycle until credit is zero
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ADD    = 3'd1;
   localparam logic [2:0] S_SERVE  = 3'd2;
   localparam logic [2:0] S_REJECT = 3'd3;
   localparam logic [2:0] S_BOUNCE = 3'd4;
   localparam logic [2:0] S_REFUND = 3'd5;

   localparam logic [CW-1:0] MAX_CREDIT = '1;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic [2:0]    prod_q, prod_d;

   logic [3:0]    req_cnt;
   logic [2:0]    req_idx;
   logic [CW-1:0] req_price;
   logic [CW-1:0] serve_price;

   function automatic logic [CW-1:0] price_of(input logic [2:0] idx);
      logic [CW-1:0] p;
      p = '0;
      for (int i = 0; i < N_PROD; i++) begin
         if (idx == 3'(i)) p = PRICES[i*CW +: CW];
      end
      return p;
   endfunction

   always_comb begin
      req_cnt = '0;
      req_idx = '0;
      for (int i = 0; i < N_PROD; i++) begin
         if (req_i[i]) begin
            req_cnt = req_cnt + 4'd1;
            req_idx = 3'(i);
         end
      end
      req_price   = price_of(req_idx);
      serve_price = price_of(prod_q);
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      prod_d   = prod_q;
      case (state_q)
         S_IDLE: begin
            if (dev_i) begin
               state_d = S_REFUND;
            end else if (req_cnt > 4'd1) begin
               state_d = S_REJECT;
            end else if (req_cnt == 4'd1) begin
               prod_d  = req_idx;
               state_d = (credit_q >= req_price) ? S_SERVE : S_REJECT;
            end else if (m100_i) begin
               state_d = (credit_q == MAX_CREDIT) ? S_BOUNCE : S_ADD;
            end
         end
         S_ADD: begin
            credit_d = credit_q + CW'(1);
            state_d  = S_IDLE;
         end
         S_SERVE: begin
            credit_d = credit_q - serve_price;
`ifdef SANDUBA_MULTI_AUTO_CHANGE_EN
            state_d  = (credit_d != '0) ? S_REFUND : S_IDLE;
`else
            state_d  = S_IDLE;
`endif
         end
         S_REFUND: begin
            // A refund entered with zero credit still lasts one cycle.
            if (credit_q != '0) begin
               credit_d = credit_q - CW'(1);
               state_d  = (credit_q == CW'(1)) ? S_IDLE : S_REFUND;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         prod_q   <= prod_d;
      end
   end

   always_comb begin
      grant_o = '0;
      if (state_q == S_SERVE) begin
         for (int i = 0; i < N_PROD; i++) begin
            if (prod_q == 3'(i)) grant_o[i] = 1'b1;
         end
      end
   end

   assign d100_o   = (state_q == S_BOUNCE) || ((state_q == S_REFUND) && (credit_q != '0));
   assign busy_o   = (state_q != S_IDLE);
   assign credit_o = credit_q;

endmodule
